// File: rtl/addsub_accumulator.sv
// Frame accumulator for sign-magnitude adder/subtractor results.
// Build option: define ADDSUB_ACC_SATURATE_EN to clamp instead of wrap.
module addsub_accumulator #(
  parameter int ACC_W = 8,
  parameter int BURST = 4,
  localparam int CW = $clog2(BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ctr,
  input  logic [3:0]       s,
  input  logic             sign,
  input  logic             c1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TW = ACC_W + 1;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q;
  logic [CW-1:0]     count_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              accept;
  logic              xfer;
  logic [4:0]        mag5;
  logic              neg;
  logic [TW-1:0]     mag_x;
  logic [TW-1:0]     v;
  logic [TW-1:0]     t;
  logic              ovf_beat;
  logic [ACC_W-1:0]  acc_d;
  logic [CW-1:0]     count_inc;
  logic              last_beat;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  // A subtract result never carries c1 into the magnitude.
  always_comb begin
    mag5  = ctr ? {1'b0, s} : {c1, s};
    neg   = ctr & sign;
    mag_x = {{(TW-5){1'b0}}, mag5};
    v     = neg ? (~mag_x + TW'(1)) : mag_x;
    t     = {acc_q[ACC_W-1], acc_q} + v;
  end

  // |v| <= 31 and ACC_W >= 6, so t never wraps at ACC_W+1 bits.
  assign ovf_beat = t[ACC_W] ^ t[ACC_W-1];

`ifdef ADDSUB_ACC_SATURATE_EN
  always_comb begin
    acc_d = t[ACC_W-1:0];
    if (ovf_beat) begin
      acc_d = t[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  always_comb begin
    acc_d = t[ACC_W-1:0];
  end
`endif

  assign count_inc = count_q + CW'(1);
  assign last_beat = (count_inc == BURST_C);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_inc;
            ovf_q   <= (state_q == RUN) ? (ovf_q | ovf_beat) : ovf_beat;
            if (last_beat) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        DONE: begin
          if (xfer) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          count_q     <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench: ACC_W=8 and ACC_W=6 instances share one stimulus stream.
module tb_addsub_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       ctr;
  logic [3:0] s;
  logic       sign;
  logic       c1;
  logic       out_ready;

  logic       in_ready8, out_valid8, ovf8;
  logic [7:0] acc8;
  logic [2:0] count8;
  logic       in_ready6, out_valid6, ovf6;
  logic [5:0] acc6;
  logic [2:0] count6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_accumulator #(.ACC_W(8), .BURST(4)) dut8 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready8),
    .ctr(ctr), .s(s), .sign(sign), .c1(c1),
    .out_valid(out_valid8), .out_ready(out_ready),
    .acc(acc8), .ovf(ovf8), .count(count8)
  );

  addsub_accumulator #(.ACC_W(6), .BURST(4)) dut6 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready6),
    .ctr(ctr), .s(s), .sign(sign), .c1(c1),
    .out_valid(out_valid6), .out_ready(out_ready),
    .acc(acc6), .ovf(ovf6), .count(count6)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic c, input logic cy, input logic [3:0] m,
                      input logic sg);
    ctr = c; c1 = cy; s = m; sign = sg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctr = 1'b0; s = 4'd0; sign = 1'b0; c1 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_acc", 32'(acc8), 32'h0);
    chk("rst_ovf", 32'(ovf8), 32'h0);
    chk("rst_count", 32'(count8), 32'h0);
    chk("rst_out_valid", 32'(out_valid8), 32'h0);
    chk("rst_in_ready", 32'(in_ready8), 32'h1);

    beat(1'b0, 1'b0, 4'd5, 1'b0);
    chk("add_lat_acc", 32'(acc8), 32'd5);
    chk("add_lat_count", 32'(count8), 32'd1);
    beat(1'b0, 1'b0, 4'd3, 1'b0);
    beat(1'b0, 1'b1, 4'd2, 1'b0);
    beat(1'b0, 1'b0, 4'd0, 1'b0);
    chk("add_acc", 32'(acc8), 32'h1A);
    chk("add_out_valid", 32'(out_valid8), 32'h1);
    chk("add_ovf", 32'(ovf8), 32'h0);
    chk("add_in_ready", 32'(in_ready8), 32'h0);
    chk("add_count", 32'(count8), 32'd4);
    take();
    chk("xfer_out_valid", 32'(out_valid8), 32'h0);
    chk("xfer_acc", 32'(acc8), 32'h0);
    chk("xfer_in_ready", 32'(in_ready8), 32'h1);

    beat(1'b1, 1'b0, 4'd7, 1'b1);
    chk("sub_first_acc", 32'(acc8), 32'hF9);
    repeat (3) beat(1'b1, 1'b0, 4'd7, 1'b1);
    chk("sub_acc", 32'(acc8), 32'hE4);
    take();
    repeat (4) beat(1'b1, 1'b1, 4'd3, 1'b0);
    chk("pos_sub_acc", 32'(acc8), 32'd12);
    chk("pos_sub_ovf", 32'(ovf8), 32'h0);
    take();

    repeat (4) beat(1'b0, 1'b0, 4'd1, 1'b0);
    ctr = 1'b0; c1 = 1'b0; s = 4'd2; sign = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_out_valid", 32'(out_valid8), 32'h1);
      chk("hold_acc", 32'(acc8), 32'd4);
      chk("hold_count", 32'(count8), 32'd4);
      chk("hold_in_ready", 32'(in_ready8), 32'h0);
    end
    take();
    chk("hold_xfer_valid", 32'(out_valid8), 32'h0);
    chk("hold_xfer_acc", 32'(acc8), 32'h0);
    chk("hold_xfer_count", 32'(count8), 32'h0);
    tick();
    in_valid = 1'b0;
    chk("held_beat_acc", 32'(acc8), 32'd2);
    chk("held_beat_count", 32'(count8), 32'd1);

    beat(1'b0, 1'b0, 4'd6, 1'b0);
    chk("pre_clear_acc", 32'(acc8), 32'd8);
    chk("pre_clear_count", 32'(count8), 32'd2);
    clear = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clear_acc", 32'(acc8), 32'h0);
    chk("clear_count", 32'(count8), 32'h0);
    chk("clear_in_ready", 32'(in_ready8), 32'h1);
    chk("clear_out_valid", 32'(out_valid8), 32'h0);
    repeat (4) beat(1'b0, 1'b0, 4'd1, 1'b0);
    chk("post_clear_acc", 32'(acc8), 32'd4);
    chk("post_clear_valid", 32'(out_valid8), 32'h1);
    take();

    beat(1'b0, 1'b1, 4'hE, 1'b0);
    chk("w6_first_acc", 32'(acc6), 32'd30);
    chk("w6_first_ovf", 32'(ovf6), 32'h0);
    repeat (3) beat(1'b0, 1'b1, 4'hE, 1'b0);
`ifdef ADDSUB_ACC_SATURATE_EN
    chk("w6_acc", 32'(acc6), 32'd31);
`else
    chk("w6_acc", 32'(acc6), 32'h38);
`endif
    chk("w6_ovf", 32'(ovf6), 32'h1);
    chk("w8_acc120", 32'(acc8), 32'd120);
    chk("w8_ovf", 32'(ovf8), 32'h0);
    take();
    chk("w6_xfer_ovf", 32'(ovf6), 32'h0);

    beat(1'b0, 1'b1, 4'hE, 1'b0);
    beat(1'b0, 1'b1, 4'hE, 1'b0);
    chk("mid_ovf6", 32'(ovf6), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_acc", 32'(acc8), 32'h0);
    chk("mrst_count", 32'(count8), 32'h0);
    chk("mrst_ovf6", 32'(ovf6), 32'h0);
    chk("mrst_in_ready", 32'(in_ready8), 32'h1);
    chk("mrst_out_valid", 32'(out_valid8), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
